// File: rtl/circle_shift_pkg.sv
// Shared constants and state type for the circular digit scroller and its unshift monitor.
package circle_shift_pkg;

    localparam int unsigned DIGIT_W_DEF = 4;
    localparam int unsigned BCD_MAX     = 9;
    // Wide enough for LOCK_FRAMES up to 7
    localparam int unsigned LOCK_CNT_W  = 3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } cu_state_e;

endpackage

// File: rtl/circle_unshift.sv
// Rebuilds a 3-digit value from the (d2,d1)->(d1,d0)->(d0,d2) scroll stream and checks continuity.
// Optional BCD range check on sampled digits: define CIRCLE_UNSHIFT_BCD_CHECK_EN.
module circle_unshift
    import circle_shift_pkg::*;
#(
    parameter int unsigned DIGIT_W     = DIGIT_W_DEF,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               frame_start,
    input  logic [DIGIT_W-1:0] in_digit_1,
    input  logic [DIGIT_W-1:0] in_digit_0,
    output logic [DIGIT_W-1:0] out_digit_2,
    output logic [DIGIT_W-1:0] out_digit_1,
    output logic [DIGIT_W-1:0] out_digit_0,
    output logic               locked,
    output logic               frame_done,
    output logic               err
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_N = LOCK_CNT_W'(LOCK_FRAMES);

    cu_state_e              state_q, state_d;
    logic [DIGIT_W-1:0]     d2_q, d1_q, d0_q, d2_d, d1_d, d0_d;
    logic [DIGIT_W-1:0]     last2_q, last1_q, last0_q, last2_d, last1_d, last0_d;
    logic [DIGIT_W-1:0]     out2_q, out1_q, out0_q, out2_d, out1_d, out0_d;
    logic [LOCK_CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic                   locked_q, locked_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   digit_bad;
    logic                   raise_err;
    logic                   same_val;

`ifdef CIRCLE_UNSHIFT_BCD_CHECK_EN
    localparam logic [DIGIT_W-1:0] BCD_LIM = DIGIT_W'(BCD_MAX);
    assign digit_bad = (in_digit_1 > BCD_LIM) || (in_digit_0 > BCD_LIM);
`else
    assign digit_bad = 1'b0;
`endif

    assign same_val = (d2_q == last2_q) && (d1_q == last1_q) && (d0_q == last0_q);
    assign cnt_next = !same_val         ? LOCK_CNT_W'(1) :
                      (cnt_q >= LOCK_N) ? LOCK_N         : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        d2_d      = d2_q;
        d1_d      = d1_q;
        d0_d      = d0_q;
        last2_d   = last2_q;
        last1_d   = last1_q;
        last0_d   = last0_q;
        out2_d    = out2_q;
        out1_d    = out1_q;
        out0_d    = out0_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        done_d    = 1'b0;
        raise_err = 1'b0;

        if (step) begin
            if (frame_start) begin
                // A frame_start always (re)captures; arriving mid-frame is a framing error
                if (digit_bad) begin
                    raise_err = 1'b1;
                    state_d   = HUNT;
                end else begin
                    d2_d      = in_digit_1;
                    d1_d      = in_digit_0;
                    state_d   = W1;
                    raise_err = (state_q == W1) || (state_q == W2);
                end
            end else begin
                unique case (state_q)
                    HUNT: ;
                    W1: begin
                        if (digit_bad || in_digit_1 != d1_q) begin
                            raise_err = 1'b1;
                            state_d   = HUNT;
                        end else begin
                            d0_d    = in_digit_0;
                            state_d = W2;
                        end
                    end
                    W2: begin
                        if (digit_bad || in_digit_1 != d0_q || in_digit_0 != d2_q) begin
                            raise_err = 1'b1;
                            state_d   = HUNT;
                        end else begin
                            done_d  = 1'b1;
                            cnt_d   = cnt_next;
                            last2_d = d2_q;
                            last1_d = d1_q;
                            last0_d = d0_q;
                            state_d = W0;
                            if (cnt_next == LOCK_N) begin
                                out2_d   = d2_q;
                                out1_d   = d1_q;
                                out0_d   = d0_q;
                                locked_d = 1'b1;
                            end else begin
                                locked_d = 1'b0;
                            end
                        end
                    end
                    W0: begin
                        raise_err = 1'b1;
                        state_d   = HUNT;
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        err_d = raise_err;
        if (raise_err) begin
            cnt_d    = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            d2_q     <= '0;
            d1_q     <= '0;
            d0_q     <= '0;
            last2_q  <= '0;
            last1_q  <= '0;
            last0_q  <= '0;
            out2_q   <= '0;
            out1_q   <= '0;
            out0_q   <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            d2_q     <= d2_d;
            d1_q     <= d1_d;
            d0_q     <= d0_d;
            last2_q  <= last2_d;
            last1_q  <= last1_d;
            last0_q  <= last0_d;
            out2_q   <= out2_d;
            out1_q   <= out1_d;
            out0_q   <= out0_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out_digit_2 = out2_q;
    assign out_digit_1 = out1_q;
    assign out_digit_0 = out0_q;
    assign locked      = locked_q;
    assign frame_done  = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_circle_unshift.sv
// Self-checking bench for circle_unshift: directed vector table, hand sequences, random stream vs. a frame-level model.
module tb_circle_unshift;

    localparam int LOCK = 2;
`ifdef CIRCLE_UNSHIFT_BCD_CHECK_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] in_digit_1 = '0;
    logic [3:0] in_digit_0 = '0;
    logic [3:0] out_digit_2, out_digit_1, out_digit_0;
    logic       locked, frame_done, err;

    circle_unshift #(.DIGIT_W(4), .LOCK_FRAMES(LOCK)) dut (
        .clk(clk), .rst(rst), .step(step), .frame_start(frame_start),
        .in_digit_1(in_digit_1), .in_digit_0(in_digit_0),
        .out_digit_2(out_digit_2), .out_digit_1(out_digit_1), .out_digit_0(out_digit_0),
        .locked(locked), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: windows of the frame in progress, plus lock bookkeeping
    int win[$];
    bit m_after;
    int m_last, m_run, m_out;
    bit m_lock;
    bit m_e, m_f;

    typedef struct {
        bit s; bit fs; int a; int b;
        bit e; bit f; bit l; int o;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dut_val();
        return int'({out_digit_2, out_digit_1, out_digit_0});
    endfunction

    task automatic model_reset();
        win.delete();
        m_after = 0; m_last = 0; m_run = 0; m_lock = 0; m_out = 0;
    endtask

    task automatic model_step(input bit fs, input int a, input int b);
        bit bad;
        int v;
        m_e = 0; m_f = 0;
        bad = BCD_EN && (a > 9 || b > 9);
        if (fs) begin
            if (bad) begin
                m_e = 1;
                win.delete();
            end else begin
                if (win.size() != 0) m_e = 1;
                win.delete();
                win.push_back(a * 16 + b);
            end
            m_after = 0;
        end else if (win.size() == 0) begin
            if (m_after) m_e = 1;
            m_after = 0;
        end else if (win.size() == 1) begin
            if (bad || a != win[0] % 16) begin
                m_e = 1;
                win.delete();
            end else begin
                win.push_back(a * 16 + b);
            end
        end else begin
            if (bad || a != win[1] % 16 || b != win[0] / 16) begin
                m_e = 1;
                win.delete();
            end else begin
                m_f = 1;
                v = win[0] * 16 + win[1] % 16;
                win.delete();
                m_after = 1;
                m_run = (v == m_last) ? ((m_run + 1 > LOCK) ? LOCK : m_run + 1) : 1;
                m_last = v;
                if (m_run == LOCK) begin
                    m_lock = 1;
                    m_out = v;
                end else begin
                    m_lock = 0;
                end
            end
        end
        if (m_e) begin
            m_run = 0;
            m_lock = 0;
        end
    endtask

    task automatic apply(input bit s, input bit fs, input int a, input int b);
        step = s; frame_start = fs;
        in_digit_1 = 4'(a); in_digit_0 = 4'(b);
        @(posedge clk); #1;
        m_e = 0; m_f = 0;
        if (s) model_step(fs, a, b);
        step = 0; frame_start = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1; step = 0; frame_start = 0;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        chk("reset_err", int'(err), 0);
        chk("reset_done", int'(frame_done), 0);
        chk("reset_lock", int'(locked), 0);
        chk("reset_out", dut_val(), 0);
        rst = 0;
    endtask

    task automatic add_frame(input int v, input bit l_end, input int o_prev, input int o_end, input bit l_pre);
        tbl.push_back('{1, 1, (v >> 8) % 16, (v >> 4) % 16, 0, 0, l_pre, o_prev});
        tbl.push_back('{1, 0, (v >> 4) % 16, v % 16, 0, 0, l_pre, o_prev});
        tbl.push_back('{1, 0, v % 16, (v >> 8) % 16, 0, 1, l_end, o_end});
    endtask

    initial begin
        int pool[3];
        int v, wa, wb;
        bit wf;

        // Clean lock
        add_frame('h952, 0, 0, 0, 0);
        add_frame('h952, 1, 0, 'h952, 0);
        // Gapped step, garbage presented while step is low
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 'h952});
        tbl.push_back('{1, 1, 9, 5, 0, 0, 1, 'h952});
        tbl.push_back('{0, 1, 7, 7, 0, 0, 1, 'h952});
        tbl.push_back('{1, 0, 5, 2, 0, 0, 1, 'h952});
        tbl.push_back('{0, 0, 3, 3, 0, 0, 1, 'h952});
        tbl.push_back('{1, 0, 2, 9, 0, 1, 1, 'h952});
        // Continuity error then re-lock
        tbl.push_back('{1, 1, 9, 5, 0, 0, 1, 'h952});
        tbl.push_back('{1, 0, 4, 2, 1, 0, 0, 'h952});
        add_frame('h952, 0, 'h952, 'h952, 0);
        add_frame('h952, 1, 'h952, 'h952, 0);
        // Framing error: window without frame_start after a completed frame
        tbl.push_back('{1, 0, 9, 5, 1, 0, 0, 'h952});
        add_frame('h952, 0, 'h952, 'h952, 0);
        add_frame('h952, 1, 'h952, 'h952, 0);
        // Value change while locked
        add_frame('h307, 0, 'h952, 'h952, 1);
        add_frame('h307, 1, 'h952, 'h307, 0);
        tbl.push_back('{1, 1, 3, 0, 0, 0, 1, 'h307});

        do_reset(2);
        foreach (tbl[i]) begin
            apply(tbl[i].s, tbl[i].fs, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e));
            chk($sformatf("tbl%0d_done", i), int'(frame_done), int'(tbl[i].f));
            chk($sformatf("tbl%0d_lock", i), int'(locked), int'(tbl[i].l));
            chk($sformatf("tbl%0d_out", i), dut_val(), tbl[i].o);
        end

        // Reset while in W1 discards the capture; a non-fs window afterwards is ignored
        do_reset(1);
        apply(1, 0, 0, 7);
        chk("post_rst_err", int'(err), 0);
        chk("post_rst_done", int'(frame_done), 0);

        // Out-of-range digits: rejected with the check built in, data otherwise
        apply(1, 1, 12, 5);
        chk("bcd_fs_err", int'(err), int'(BCD_EN));
        apply(1, 0, 5, 2);
        chk("bcd_w1_err", int'(err), 0);
        apply(1, 0, 2, 12);
        chk("bcd_w2_err", int'(err), 0);
        chk("bcd_w2_done", int'(frame_done), int'(!BCD_EN));
        apply(1, 1, 9, 5);
        chk("bcd_next_err", int'(err), 0);
        chk("bcd_lock", int'(locked), 0);

        // Random stream from a small value pool, with gaps, corruption and resets
        do_reset(1);
        for (int n = 0; n < 700; n++) begin
            if (n % 100 == 0) begin
                pool[0] = int'($urandom_range(0, 'h999)) & 'h777;
                pool[1] = int'($urandom_range(0, 9)) * 'h111;
                pool[2] = int'($urandom_range(0, 'hfff));
            end
            v = pool[$urandom_range(0, 2)];
            for (int k = 0; k < 3; k++) begin
                wf = (k == 0);
                wa = (k == 0) ? (v >> 8) % 16 : (k == 1) ? (v >> 4) % 16 : v % 16;
                wb = (k == 0) ? (v >> 4) % 16 : (k == 1) ? v % 16 : (v >> 8) % 16;
                if ($urandom_range(0, 24) == 0) begin
                    wa = int'($urandom_range(0, 15));
                    wb = int'($urandom_range(0, 15));
                    wf = bit'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 3) == 0) begin
                    apply(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                    chk("rnd_gap_err", int'(err), 0);
                    chk("rnd_gap_done", int'(frame_done), 0);
                    chk("rnd_gap_lock", int'(locked), int'(m_lock));
                    chk("rnd_gap_out", dut_val(), m_out);
                end
                apply(1, wf, wa, wb);
                chk("rnd_err", int'(err), int'(m_e));
                chk("rnd_done", int'(frame_done), int'(m_f));
                chk("rnd_lock", int'(locked), int'(m_lock));
                chk("rnd_out", dut_val(), m_out);
            end
            if ($urandom_range(0, 149) == 0) do_reset(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
